ws_gen_tdm: RTL

WS_GEN_TDM -- requirements
Module: ws_gen_tdm

---
 rtl/ws_gen_tdm_if.sv | 37 +++
 rtl/ws_gen_tdm.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ws_gen_tdm_if.sv
// Word-select / TDM frame generator bus.
// Controller drives requests and config; the generator drives timing.
interface ws_gen_tdm_if #(
    parameter int MAX_SLOTS = 8
);
    localparam int NSW = $clog2(MAX_SLOTS + 1);
    localparam int SW  = $clog2(MAX_SLOTS);

    logic           en;
    logic           stop;
    logic           mode;
    logic           tx_empty;
    logic           rx_full;
    logic [1:0]     std;
    logic [1:0]     slot_len;
    logic [NSW-1:0] num_slots;
    logic           ws;
    logic [SW-1:0]  slot_idx;
    logic [4:0]     bit_cnt;
    logic           frame_start;
    logic           slot_last;
    logic           busy;

    modport master (
        output en, stop, mode, tx_empty, rx_full,
        output std, slot_len, num_slots,
        input  ws, slot_idx, bit_cnt,
        input  frame_start, slot_last, busy
    );

    modport slave (
        input  en, stop, mode, tx_empty, rx_full,
        input  std, slot_len, num_slots,
        output ws, slot_idx, bit_cnt,
        output frame_start, slot_last, busy
    );
endinterface

// File: rtl/ws_gen_tdm.sv
// Word-select / frame-sync generator for I2S, left-justified and DSP/TDM.
// Frame geometry is shadowed at each frame start; frames always complete.
module ws_gen_tdm #(
    parameter int MAX_SLOTS = 8,
    parameter int PULSE_W   = 1
) (
    input  logic       clk,
    input  logic       rst_,
    ws_gen_tdm_if.slave bus
);
    localparam int NSW = $clog2(MAX_SLOTS + 1);
    localparam int SW  = $clog2(MAX_SLOTS);

    localparam logic [NSW-1:0] MAX_N = NSW'(MAX_SLOTS);
    localparam logic [4:0]     PW    = 5'(PULSE_W);

    localparam logic [1:0] STD_LJ  = 2'b01;
    localparam logic [1:0] STD_DSP = 2'b10;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     std_s_q, std_s_d;
    logic [1:0]     len_s_q, len_s_d;
    logic [NSW-1:0] nsl_s_q, nsl_s_d;
    logic [SW-1:0]  slot_q, slot_d;
    logic [4:0]     bit_q, bit_d;
    logic           ws_q, ws_d;
    logic           fs_q, fs_d;
    logic           sl_q, sl_d;

    logic           go;
    logic           last_bit;
    logic           last_frame;
    logic           start;
    logic           act_d;
    logic           idle_ws;
    logic [NSW-1:0] nsl_in;

    function automatic logic [4:0] len_m1(input logic [1:0] code);
        logic [4:0] r;
        unique case (code)
            2'b00:   r = 5'd15;
            2'b01:   r = 5'd23;
            default: r = 5'd31;
        endcase
        return r;
    endfunction

    // Start/continue condition, only consulted in IDLE or at frame end.
    always_comb begin
        go = bus.en & ~bus.stop &
             (bus.mode ? ~bus.rx_full : ~bus.tx_empty);
    end

    // Slot count clamped into 1..MAX_SLOTS before it is shadowed.
    always_comb begin
        nsl_in = bus.num_slots;
        if (bus.num_slots == '0) begin
            nsl_in = NSW'(1);
        end else if (bus.num_slots > MAX_N) begin
            nsl_in = MAX_N;
        end
    end

    // Next-state, counters and registered output values.
    always_comb begin
        state_d  = state_q;
        std_s_d  = std_s_q;
        len_s_d  = len_s_q;
        nsl_s_d  = nsl_s_q;
        slot_d   = '0;
        bit_d    = '0;
        start    = 1'b0;
        last_bit   = (bit_q == len_m1(len_s_q));
        last_frame = last_bit &&
                     (NSW'(slot_q) == nsl_s_q - 1'b1);

        if (state_q == IDLE) begin
            start = go;
        end else if (last_frame) begin
            start = go;
            if (!go) begin
                state_d = IDLE;
            end
        end else if (last_bit) begin
            slot_d = slot_q + 1'b1;
        end else begin
            slot_d = slot_q;
            bit_d  = bit_q + 5'd1;
        end

        if (start) begin
            state_d = ACTIVE;
            std_s_d = bus.std;
            len_s_d = bus.slot_len;
            nsl_s_d = nsl_in;
        end

        act_d   = (state_d == ACTIVE);
        fs_d    = start;
        sl_d    = act_d && (bit_d == len_m1(len_s_d));
        idle_ws = (std_s_d != STD_LJ) && (std_s_d != STD_DSP);

        if (!act_d) begin
            ws_d = idle_ws;
        end else if (std_s_d == STD_LJ) begin
            ws_d = ~slot_d[0];
        end else if (std_s_d == STD_DSP) begin
            // A slot is at least 16 clocks, so the pulse never leaves slot 0.
            ws_d = (slot_d == '0) && (bit_d < PW);
        end else begin
            ws_d = slot_d[0];
        end
    end

    // State, shadow and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q <= IDLE;
            std_s_q <= 2'b00;
            len_s_q <= 2'b10;
            nsl_s_q <= NSW'(2);
            slot_q  <= '0;
            bit_q   <= '0;
            ws_q    <= 1'b1;
            fs_q    <= 1'b0;
            sl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            std_s_q <= std_s_d;
            len_s_q <= len_s_d;
            nsl_s_q <= nsl_s_d;
            slot_q  <= slot_d;
            bit_q   <= bit_d;
            ws_q    <= ws_d;
            fs_q    <= fs_d;
            sl_q    <= sl_d;
        end
    end

    assign bus.ws          = ws_q;
    assign bus.slot_idx    = slot_q;
    assign bus.bit_cnt     = bit_q;
    assign bus.frame_start = fs_q;
    assign bus.slot_last   = sl_q;
    assign bus.busy        = (state_q == ACTIVE);
endmodule
